// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the per-sample FIR band MAC scheduler.
package fir_sched_pkg;

   localparam int unsigned NUM_BANDS_DEF = 5;
   localparam int unsigned LO_BANDS_DEF  = 2;
   localparam int unsigned TAPS_LO_DEF   = 531;
   localparam int unsigned TAPS_HI_DEF   = 1021;
   localparam int unsigned PIPE_LAT_DEF  = 2;
   localparam int unsigned TAP_CNT_W     = $clog2(TAPS_HI_DEF);

   typedef logic [$clog2(NUM_BANDS_DEF)-1:0] band_idx_t;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      RUN,
      DRAIN,
      DONE,
      SKIP
   } sched_state_t;

   function automatic int unsigned taps_of(input band_idx_t b, input int unsigned lo_bands,
                                           input int unsigned taps_lo, input int unsigned taps_hi);
      return (32'(b) < lo_bands) ? taps_lo : taps_hi;
   endfunction

endpackage

// File: rtl/sched_dly_line.sv
// Fixed-depth 1-bit delay line; aligns the read-issue strobe with product arrival.
module sched_dly_line #(
   parameter int unsigned DEPTH = 2
)(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/fir_band_sched.sv
// Per-sample MAC scheduler sharing one coefficient ROM/MAC across all FIR bands.
// Optional build macro FIR_BAND_MASK_EN adds a per-band enable input (band_en).
module fir_band_sched
   import fir_sched_pkg::*;
#(
   parameter int unsigned NUM_BANDS = NUM_BANDS_DEF,
   parameter int unsigned LO_BANDS  = LO_BANDS_DEF,
   parameter int unsigned TAPS_LO   = TAPS_LO_DEF,
   parameter int unsigned TAPS_HI   = TAPS_HI_DEF,
   parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         smpl_rdy,
   input  logic                         lo_full,
   input  logic                         hi_full,
   input  logic                         clr_ovr,
`ifdef FIR_BAND_MASK_EN
   input  logic [NUM_BANDS-1:0]         band_en,
`endif
   output logic                         seq_lo,
   output logic                         seq_hi,
   output logic [$clog2(NUM_BANDS)-1:0] band,
   output logic [$clog2(TAPS_HI)-1:0]   coeff_addr,
   output logic                         clr_acc,
   output logic                         acc_en,
   output logic                         band_done,
   output logic                         band_vld,
   output logic                         all_done,
   output logic                         busy,
   output logic                         ovr
);

   localparam int unsigned BAND_W = $clog2(NUM_BANDS);
   localparam int unsigned TAP_W  = $clog2(TAPS_HI);
   localparam int unsigned DRN_W  = $clog2(PIPE_LAT + 1);

   sched_state_t         state;
   logic                 rd_issue;
   logic [DRN_W-1:0]     drn_cnt;
   logic [NUM_BANDS-1:0] en_mask;
   logic [BAND_W-1:0]    entry_band;
   logic                 entry_ok;
   logic                 entry_last;
   logic                 enter;
   logic                 band_last;
   logic                 band_is_lo;
   logic [TAP_W-1:0]     last_addr;

`ifdef FIR_BAND_MASK_EN
   assign en_mask = band_en;
`else
   assign en_mask = '1;
`endif

   // Band entry happens from IDLE (band 0) or after a DONE/SKIP that is not the last band.
   always_comb begin
      entry_band = (state == IDLE) ? '0 : band + 1'b1;
      entry_ok   = ((entry_band < BAND_W'(LO_BANDS)) ? lo_full : hi_full) && en_mask[entry_band];
      entry_last = (entry_band == BAND_W'(NUM_BANDS - 1));
      band_last  = (band == BAND_W'(NUM_BANDS - 1));
      band_is_lo = (band < BAND_W'(LO_BANDS));
      last_addr  = TAP_W'(taps_of(band_idx_t'(band), LO_BANDS, TAPS_LO, TAPS_HI) - 1);
      enter      = ((state == IDLE) && smpl_rdy) ||
                   (((state == DONE) || (state == SKIP)) && !band_last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         band       <= '0;
         coeff_addr <= '0;
         drn_cnt    <= '0;
         rd_issue   <= 1'b0;
         seq_lo     <= 1'b0;
         seq_hi     <= 1'b0;
         clr_acc    <= 1'b0;
         band_done  <= 1'b0;
         band_vld   <= 1'b0;
         all_done   <= 1'b0;
         busy       <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         rd_issue  <= 1'b0;
         seq_lo    <= 1'b0;
         seq_hi    <= 1'b0;
         clr_acc   <= 1'b0;
         band_done <= 1'b0;
         band_vld  <= 1'b0;
         all_done  <= 1'b0;

         if (smpl_rdy && busy) begin
            ovr <= 1'b1;
         end else if (clr_ovr) begin
            ovr <= 1'b0;
         end

         if (enter) begin
            band       <= entry_band;
            coeff_addr <= '0;
            busy       <= 1'b1;
            if (entry_ok) begin
               state   <= CLR;
               clr_acc <= 1'b1;
            end else begin
               state     <= SKIP;
               band_done <= 1'b1;
               all_done  <= entry_last;
            end
         end else begin
            case (state)
               CLR: begin
                  state    <= RUN;
                  rd_issue <= 1'b1;
                  seq_lo   <= band_is_lo;
                  seq_hi   <= !band_is_lo;
               end
               RUN: begin
                  if (coeff_addr == last_addr) begin
                     state   <= DRAIN;
                     drn_cnt <= '0;
                  end else begin
                     coeff_addr <= coeff_addr + 1'b1;
                     rd_issue   <= 1'b1;
                     seq_lo     <= band_is_lo;
                     seq_hi     <= !band_is_lo;
                  end
               end
               DRAIN: begin
                  if (drn_cnt == DRN_W'(PIPE_LAT - 1)) begin
                     state     <= DONE;
                     band_done <= 1'b1;
                     band_vld  <= 1'b1;
                     all_done  <= band_last;
                  end else begin
                     drn_cnt <= drn_cnt + 1'b1;
                  end
               end
               DONE, SKIP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   sched_dly_line #(
      .DEPTH(PIPE_LAT)
   ) u_dly (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (rd_issue),
      .q    (acc_en)
   );

endmodule

// File: doc/fir_band_sched.md
Name: fir_band_sched

Overview:
Per-sample MAC scheduler for the equalizer filter bank. It is triggered by each new sample written into the low and high frequency queues. It time-multiplexes one shared coefficient ROM and MAC datapath across all FIR bands in sequence, driving queue read sequencing, coefficient address, accumulator clear/enable and per-band completion strobes. It sits between the queues/I2S_Serf valid strobe and the band FIR/MAC datapath.

Parameters:
NUM_BANDS, 5, number of bands sequenced per sample (LP, B1, B2, B3, HP)
LO_BANDS, 2, bands 0..LO_BANDS-1 read the low-freq queue; the rest read the high-freq queue
TAPS_LO, 531, taps per low-queue band
TAPS_HI, 1021, taps per high-queue band
PIPE_LAT, 2, cycles from read/address issue to product valid at the accumulator

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
smpl_rdy  in  1  one-cycle pulse: new L/R sample written to both queues
lo_full  in  1  low-freq queue holds TAPS_LO samples
hi_full  in  1  high-freq queue holds TAPS_HI samples
clr_ovr  in  1  clears the ovr sticky bit
seq_lo  out  1  read-sequencing enable to the low-freq queue
seq_hi  out  1  read-sequencing enable to the high-freq queue
band  out  $clog2(NUM_BANDS)  index of the band currently being processed
coeff_addr  out  $clog2(TAPS_HI)  coefficient ROM address, counts 0..taps-1
clr_acc  out  1  clear the accumulator
acc_en  out  1  accumulate the product this cycle
band_done  out  1  one-cycle pulse: accumulator for `band` is final
band_vld  out  1  qualifies band_done; 0 means the band was skipped
all_done  out  1  one-cycle pulse coincident with the last band_done
busy  out  1  a frame is in progress
ovr  out  1  sticky: smpl_rdy arrived while busy

Behaviour:
- Reset values: all outputs 0, band=0, coeff_addr=0, state IDLE, delay line cleared. Reset mid-frame aborts the frame immediately; no done pulses are issued.
- Cycle numbering: the edge sampling smpl_rdy=1 in IDLE is cycle 0.
- FSM states: IDLE, CLR, RUN, DRAIN, DONE, SKIP.
- IDLE: on smpl_rdy, set band=0 and go to CLR, or to SKIP if band 0's queue is not full.
- CLR: 1 cycle. clr_acc=1 and busy=1.
- RUN: exactly taps(band) cycles. coeff_addr runs 0..taps-1. seq_lo or seq_hi (by band) is 1 and rd_issue is 1.
- DRAIN: PIPE_LAT cycles. No read is issued.
- DONE: 1 cycle. band_done=1 and band_vld=1. Then either increment band and go to CLR/SKIP, or, if band==NUM_BANDS-1, assert all_done and go to IDLE.
- SKIP: 1 cycle. band_done=1 and band_vld=0. Next-band and last-band rules are the same as DONE.
- Queue fullness is sampled at band entry. A queue filling mid-frame does not affect the band already in progress.
- acc_en equals rd_issue delayed by PIPE_LAT cycles. It is therefore high for exactly taps cycles, ending on the last DRAIN cycle. It is never high in DONE, SKIP or CLR.
- Per-band cost is 1+taps+PIPE_LAT+1 cycles; a skipped band costs 1 cycle.
- busy is 1 from cycle 1 through the all_done cycle inclusive.
- coeff_addr returns to 0 at band entry and holds its value in DRAIN/DONE/SKIP.
- smpl_rdy while busy: the sample is ignored, the frame continues, and ovr is set next cycle.
- ovr clearing: clr_ovr clears ovr. If smpl_rdy (while busy) and clr_ovr occur in the same cycle, set wins.
- smpl_rdy coincident with the all_done cycle counts as an overrun.

Optional Feature:
FIR_BAND_MASK_EN:
- When defined: adds input band_en[NUM_BANDS-1:0]. A band with band_en=0 takes the SKIP path (band_vld=0) regardless of fullness. band_en is sampled at band entry.
- When undefined: the port is absent and all bands are enabled.

Decomposition:
- Package fir_sched_pkg holds:
  - state enum sched_state_t
  - band_idx_t
  - tap count width constant
  - function taps_of(band) returning TAPS_LO/TAPS_HI
- Sub-module sched_dly_line: PIPE_LAT-deep 1-bit shift register with async reset, producing acc_en from rd_issue.

Test Plan:
(Simulation parameters: TAPS_LO=4, TAPS_HI=6, PIPE_LAT=2.)
- Full frame, lo_full=hi_full=1, smpl_rdy at cycle 0 -> band_done at cycles 8, 16, 26, 36, 46, all with band_vld=1. all_done at 46, busy low at 47. acc_en high 4,4,6,6,6 cycles; clr_acc at cycles 1, 9, 17, 27, 37.
- lo_full=0, hi_full=1 -> band_done with band_vld=0 at cycles 1 and 2; valid band_done at 12, 22 and 32; all_done at 32. seq_lo never asserted.
- coeff_addr check in band 2 -> 0,1,2,3,4,5 over cycles 18-23, holds 5 through cycle 26. seq_hi high exactly in cycles 18-23.
- smpl_rdy again at cycle 20 -> frame unaffected (all_done at 46), ovr=1 at cycle 21. clr_ovr at cycle 50 -> ovr=0 at 51. A new smpl_rdy at 50 starts a frame (clr_acc at 51).
- rst_n low at cycle 25 -> all outputs 0 asynchronously, no band_done issued. After release, a smpl_rdy runs a clean full frame.
- FIR_BAND_MASK_EN, band_en=5'b10101, all queues full -> bands 1 and 3 produce band_vld=0 pulses. Bands 0, 2 and 4 run full MAC sequences; all_done at 1+8+1+10+1+10-1 (band 4 DONE).
